// File: rtl/bin_to_bcd_pkg.sv
// Shared constants and FSM state type for the iterative binary-to-BCD converter.
package bin_to_bcd_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DIGITS   = 10;
  localparam int unsigned BCD_W    = 4 * DIGITS + 1;
  localparam int unsigned SIGN_BIT = BCD_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential shift-add-3 converter: two's-complement word in, sign plus packed
// BCD magnitude out, one input bit per clock.
module bin_to_bcd #(
  parameter int unsigned DATA_W = bin_to_bcd_pkg::DATA_W,
  parameter int unsigned DIGITS = bin_to_bcd_pkg::DIGITS,
  parameter int unsigned SIGNED = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [DATA_W-1:0]   input_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*DIGITS:0]   bcds,
  output logic                out_valid
);

  import bin_to_bcd_pkg::*;

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned SCR_W = 4 * DIGITS;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  mag, mag_nxt, in_mag;
  logic [SCR_W-1:0]   scratch, scratch_nxt, adj;
  logic [CNT_W-1:0]   cnt;
  logic               sign_r, in_neg, last_bit;

  always_comb begin
    in_neg = (SIGNED != 0) && input_data[DATA_W-1];
    in_mag = in_neg ? (~input_data + DATA_W'(1)) : input_data;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3_digit u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Scratch and magnitude shift as one long register so the magnitude MSB
  // feeds the BCD LSB; the top bit falls off and is always 0 after add-3.
  always_comb begin
    {scratch_nxt, mag_nxt} = {adj, mag} << 1;
    last_bit               = (cnt == CNT_W'(DATA_W - 1));
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mag     <= '0;
      scratch <= '0;
      cnt     <= '0;
      sign_r  <= 1'b0;
      bcds    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mag     <= in_mag;
            scratch <= '0;
            cnt     <= '0;
            sign_r  <= in_neg && (in_mag != '0);
          end
        end
        SHIFT: begin
          mag     <= mag_nxt;
          scratch <= scratch_nxt;
          cnt     <= cnt + CNT_W'(1);
          if (last_bit) bcds <= {sign_r, scratch_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: driver queues expected results, monitors
// compare whenever out_valid pulses.
module tb_bin_to_bcd;

  typedef struct {
    logic [40:0] bcds;
    int unsigned acc;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] input_data, input_data_u;
  logic        in_valid, in_valid_u;
  logic        in_ready, in_ready_u;
  logic [40:0] bcds, bcds_u;
  logic        out_valid, out_valid_u;

  exp_t        q[$];
  exp_t        qu[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned last_ov_cyc = 0;
  logic [40:0] last_bcds = '0;

  bin_to_bcd #(.DATA_W(32), .DIGITS(10), .SIGNED(1)) u_dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .input_data (input_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bcds       (bcds),
    .out_valid  (out_valid)
  );

  bin_to_bcd #(.DATA_W(32), .DIGITS(10), .SIGNED(0)) u_dut_uns (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .input_data (input_data_u),
    .in_valid   (in_valid_u),
    .in_ready   (in_ready_u),
    .bcds       (bcds_u),
    .out_valid  (out_valid_u)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference by repeated division, independent of the shift-add-3 datapath.
  function automatic logic [40:0] ref_bcd(input logic [31:0] x, input bit sgn);
    logic [63:0] m;
    logic        neg;
    logic [40:0] r;
    neg = sgn && x[31];
    m   = neg ? (64'd4294967296 - {32'd0, x}) : {32'd0, x};
    r   = '0;
    r[40] = neg && (m != 64'd0);
    for (int k = 0; k < 10; k++) begin
      r[4*k +: 4] = 4'(m % 64'd10);
      m = m / 64'd10;
    end
    return r;
  endfunction

  task automatic send(input logic [31:0] d, input logic [40:0] exp);
    int unsigned k = 0;
    @(negedge sys_clk);
    while (!in_ready && k < 200) begin
      @(negedge sys_clk);
      k++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      return;
    end
    input_data = d;
    in_valid   = 1'b1;
    @(posedge sys_clk);
    #1;
    q.push_back('{exp, cyc});
    in_valid = 1'b0;
  endtask

  task automatic send_u(input logic [31:0] d, input logic [40:0] exp);
    int unsigned k = 0;
    @(negedge sys_clk);
    while (!in_ready_u && k < 200) begin
      @(negedge sys_clk);
      k++;
    end
    if (!in_ready_u) begin
      chk("accept_timeout_u", 64'd0, 64'd1);
      return;
    end
    input_data_u = d;
    in_valid_u   = 1'b1;
    @(posedge sys_clk);
    #1;
    qu.push_back('{exp, cyc});
    in_valid_u = 1'b0;
  endtask

  initial begin : monitor
    exp_t        e;
    int unsigned bad_dig;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (out_valid) begin
          if (q.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk("bcds", 64'(bcds), 64'(e.bcds));
            chk("latency", 64'(cyc), 64'(e.acc + 32));
          end
          bad_dig = 0;
          for (int k = 0; k < 10; k++) if (bcds[4*k +: 4] > 4'd9) bad_dig++;
          chk("digit_range", 64'(bad_dig), 64'd0);
          last_bcds   = bcds;
          last_ov_cyc = cyc;
        end else begin
          chk("bcds_stable", 64'(bcds), 64'(last_bcds));
        end
      end
    end
  end

  initial begin : monitor_u
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && out_valid_u) begin
        if (qu.size() == 0) chk("spurious_out_valid_u", 64'd1, 64'd0);
        else begin
          e = qu.pop_front();
          chk("bcds_u", 64'(bcds_u), 64'(e.bcds));
          chk("latency_u", 64'(cyc), 64'(e.acc + 32));
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int unsigned pulses;
    int unsigned ready_cyc;
    bit          got_ready;
    logic [31:0] x;

    sys_rst_n    = 1'b0;
    in_valid     = 1'b0;
    input_data   = '0;
    in_valid_u   = 1'b0;
    input_data_u = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("rst_bcds", 64'(bcds), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Abort a conversion part-way with an asynchronous reset.
    input_data = 32'd12345;
    in_valid   = 1'b1;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_bcds", 64'(bcds), 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (out_valid) pulses++;
    end
    chk("midrst_no_pulse", 64'(pulses), 64'd0);
    chk("midrst_bcds_after", 64'(bcds), 64'd0);

    send(32'h0000_04D2, 41'h0_0000001234);
    send(32'hFFFF_FFFF, 41'h1_0000000001);
    send(32'h8000_0000, 41'h1_2147483648);
    send(32'h7FFF_FFFF, 41'h0_2147483647);
    send(32'h0000_0009, 41'h0_0000000009);
    send(32'h0000_000A, 41'h0_0000000010);
    send(32'hFFFF_FFF6, 41'h1_0000000010);
    send_u(32'hFFFF_FFFF, 41'h0_4294967295);
    send_u(32'h8000_0000, 41'h0_2147483648);

    // Zero, then keep in_valid high with changing data through the conversion.
    send(32'h0000_0000, 41'h0_0000000000);
    @(negedge sys_clk);
    while (!in_ready) @(negedge sys_clk);
    input_data = 32'd0;
    in_valid   = 1'b1;
    @(posedge sys_clk);
    #1;
    q.push_back('{41'h0_0000000000, cyc});
    got_ready = 1'b0;
    ready_cyc = 0;
    for (int i = 0; i < 80 && !got_ready; i++) begin
      @(negedge sys_clk);
      input_data = 32'd100 + 32'(i);
      if (in_ready) begin
        got_ready = 1'b1;
        ready_cyc = cyc;
        q.push_back('{ref_bcd(input_data, 1'b1), cyc + 1});
        @(posedge sys_clk);
        #1;
      end
    end
    in_valid = 1'b0;
    chk("hold_ready_seen", 64'(got_ready), 64'd1);
    chk("ready_after_ov", 64'(ready_cyc), 64'(last_ov_cyc + 1));

    for (int i = 0; i < 1000; i++) begin
      x = (i % 4 == 0) ? $urandom_range(0, 99999) : $urandom;
      send(x, ref_bcd(x, 1'b1));
    end

    for (int k = 0; k < 500 && (q.size() != 0 || qu.size() != 0); k++) @(negedge sys_clk);
    chk("drain_q", 64'(q.size()), 64'd0);
    chk("drain_qu", 64'(qu.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd.md
Name: bin_to_bcd

Overview:
- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm.
- Takes a two's-complement word and produces a sign flag plus 10 packed BCD digits of the magnitude.
- Feeds the 4-digit seven-segment display driver, which shows the sign and the low-order digits.
- Iterative: one bit per clock, so one conversion takes DATA_W cycles.

Parameters:
- DATA_W, 32: width of the binary input.
- DIGITS, 10: number of BCD output digits. Must be at least the decimal digit count of 2^DATA_W-1 (10 for 32 bits).
- SIGNED, 1: 1 = input is two's complement, convert |x| and report the sign; 0 = input is unsigned, sign bit is forced to 0.

Ports:
- sys_clk  input  1  clock; all state changes on the rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- input_data  input  DATA_W  value to convert; sampled only on accept.
- in_valid  input  1  request to convert input_data.
- in_ready  output  1  high when idle and able to accept.
- bcds  output  4*DIGITS+1 (41)  [40] = sign (1 = negative); [4k+3:4k] = decimal digit k, with k=0 the least significant digit; registered.
- out_valid  output  1  one-cycle pulse when bcds has just been updated.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-conversion):
  - state=IDLE, bcds=0, out_valid=0, in_ready=1.
  - Any conversion in progress is discarded.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid=1 at a rising edge (edge N).
  - On accept: magnitude = (SIGNED && input_data[MSB]) ? (~input_data+1) : input_data, taken at DATA_W bits.
  - For input 0x80000000 this yields 2147483648, which is correct as unsigned.
  - On accept: latch the sign, clear the BCD scratch register, set bit counter=0, go to SHIFT.
- SHIFT:
  - in_ready=0; in_valid is ignored and no request is queued.
  - Each edge: every scratch digit >=5 gets +3, then {scratch, magnitude} shifts left by 1.
  - After DATA_W edges (edge N+DATA_W), the final scratch value and sign are written to bcds, and the state goes to DONE.
- DONE:
  - out_valid=1 for exactly this one cycle; in_ready=0.
  - The next edge returns to IDLE.
- Latency: out_valid is high in the cycle after edge N+32, with bcds valid in that same cycle. Throughput is one conversion per 34 cycles.
- bcds holds the last result until the next completion. It never shows partial values.
- Zero is never reported as negative: a zero magnitude forces sign=0.
- Digits are never greater than 9. Leading digits are 0 (no blanking).

Decomposition:
- Package bin_to_bcd_pkg holds:
  - constants DATA_W=32, DIGITS=10, BCD_W=4*DIGITS+1;
  - state enum {IDLE, SHIFT, DONE};
  - sign-bit index localparam.
- One natural sub-module: bcd_add3_digit.
  - Combinational 4-bit in, 4-bit out (in>=5 ? in+3 : in).
  - Instantiated DIGITS times via generate.

Test Plan:
- Reset checks:
  - After reset, bcds=0, out_valid=0, in_ready=1.
  - Assert reset during SHIFT: state returns to IDLE, bcds stays 0, and no out_valid pulse follows.
- Accept 0x000004D2 (1234): bcds=41'h0_0000001234; out_valid high exactly in the cycle after accept edge +32.
- Accept 0xFFFFFFFF (-1): bcds[40]=1, digits=0000000001. Accept 0x80000000: bcds[40]=1, digits=2147483648.
- Accept 0x7FFFFFFF: bcds[40]=0, digits=2147483647. With SIGNED=0, 0xFFFFFFFF gives sign 0, digits=4294967295.
- Accept 0 (sign 0, all digits 0), then hold in_valid=1 with changing data during SHIFT:
  - Only the first value converts.
  - in_ready rises the cycle after out_valid.
  - The next accept captures the value present then.
- Random sweep of 1000 values compared against a reference model; additionally check every digit is <=9 and bcds is stable between out_valid pulses.
